vga_timing_gen: RTL and testbench

Generates the VGA raster timing that the pixel/colour logic consumes: hCount, vCount, bright, hSync and vSync for 640x480 at 60 Hz. The 100 MHz board clock is divided to the 25 MHz pixel rate with a clock-enable, not a derived clock. It also provides per-frame pulses and a frame counter for game-logic animation and physics stepping. The block sits at the top level, driving the VGA connector pins and feeding the counters to the pixel-colour block.

---
 rtl/vga_timing_gen.sv | 147 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: a clock-enable pixel divider drives h/v counters,
// registered syncs/bright aligned to the counters, and a per-frame tick/counter.

// Elaboration-time legality check for the timing parameters.
module vga_timing_gen_param_chk #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_VIS_START = 144,
  parameter int unsigned H_VIS_END   = 784,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_VIS_START = 35,
  parameter int unsigned V_VIS_END   = 515,
  parameter int unsigned V_TOTAL     = 525
) ();
  if (!((CLK_DIV >= 32'd1) && (CLK_DIV <= 32'd16))) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be in 1..16");
  end
  if (!((H_SYNC < H_VIS_START) && (H_VIS_START < H_VIS_END) &&
        (H_VIS_END <= H_TOTAL) && (H_TOTAL <= 32'd1024))) begin : g_bad_h
    $error("vga_timing_gen: illegal horizontal timing parameters");
  end
  if (!((V_SYNC < V_VIS_START) && (V_VIS_START < V_VIS_END) &&
        (V_VIS_END <= V_TOTAL) && (V_TOTAL <= 32'd1024))) begin : g_bad_v
    $error("vga_timing_gen: illegal vertical timing parameters");
  end
endmodule

module vga_timing_gen #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_VIS_START = 144,
  parameter int unsigned H_VIS_END   = 784,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_VIS_START = 35,
  parameter int unsigned V_VIS_END   = 515,
  parameter int unsigned V_TOTAL     = 525
) (
  input  logic       clk,
  input  logic       reset_button,
  output logic       pix_en,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       frame_tick,
  output logic [7:0] frame_count
);

  localparam int unsigned DIV_W = (CLK_DIV > 32'd1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 32'd1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(32'd1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(32'd0);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 32'd1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 32'd1);
  localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
  localparam logic [9:0] H_VS_W  = 10'(H_VIS_START);
  localparam logic [9:0] H_VE_W  = 10'(H_VIS_END);
  localparam logic [9:0] V_VS_W  = 10'(V_VIS_START);
  localparam logic [9:0] V_VE_W  = 10'(V_VIS_END);

  vga_timing_gen_param_chk #(
    .CLK_DIV(CLK_DIV), .H_SYNC(H_SYNC), .H_VIS_START(H_VIS_START),
    .H_VIS_END(H_VIS_END), .H_TOTAL(H_TOTAL), .V_SYNC(V_SYNC),
    .V_VIS_START(V_VIS_START), .V_VIS_END(V_VIS_END), .V_TOTAL(V_TOTAL)
  ) u_param_chk ();

  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] div_next_s;
  logic             tick_s;
  logic             line_end_s;
  logic             frame_end_s;
  logic             wrap_s;
  logic [9:0]       h_next_s;
  logic [9:0]       v_next_s;
  logic             hsync_next_s;
  logic             vsync_next_s;
  logic             bright_next_s;

  // Divider and raster counter next-state; ">=" keeps an out-of-range count wrapping.
  always_comb begin
    tick_s      = (div_r >= DIV_LAST);
    line_end_s  = (hCount >= H_LAST);
    frame_end_s = (vCount >= V_LAST);
    div_next_s  = div_r;
    h_next_s    = hCount;
    v_next_s    = vCount;
    wrap_s      = 1'b0;
    if (tick_s) begin
      div_next_s = DIV_ZERO;
      if (line_end_s) begin
        h_next_s = 10'd0;
        if (frame_end_s) begin
          v_next_s = 10'd0;
          wrap_s   = 1'b1;
        end else begin
          v_next_s = vCount + 10'd1;
        end
      end else begin
        h_next_s = hCount + 10'd1;
      end
    end else begin
      div_next_s = div_r + DIV_ONE;
    end
  end

  // Syncs and bright decoded from the next counter values so they stay aligned.
  always_comb begin
    hsync_next_s  = (h_next_s >= H_SYNC_W);
    vsync_next_s  = (v_next_s >= V_SYNC_W);
    bright_next_s = (h_next_s >= H_VS_W) && (h_next_s < H_VE_W) &&
                    (v_next_s >= V_VS_W) && (v_next_s < V_VE_W);
  end

  // Timing state and registered outputs.
  always_ff @(posedge clk or posedge reset_button) begin
    if (reset_button) begin
      div_r       <= DIV_ZERO;
      pix_en      <= 1'b0;
      hCount      <= 10'd0;
      vCount      <= 10'd0;
      hSync       <= 1'b0;
      vSync       <= 1'b0;
      bright      <= 1'b0;
      frame_tick  <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      div_r      <= div_next_s;
      pix_en     <= tick_s;
      hCount     <= h_next_s;
      vCount     <= v_next_s;
      hSync      <= hsync_next_s;
      vSync      <= vsync_next_s;
      bright     <= bright_next_s;
      frame_tick <= wrap_s;
      if (wrap_s) begin
        frame_count <= frame_count + 8'd1;
      end else begin
        frame_count <= frame_count;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three builds (small raster, defaults, CLK_DIV=1 tiny raster)
// checked every cycle against a raster-arithmetic model, plus literal pins.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       pe;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       br;
    logic       ft;
    logic [7:0] fc;
  } obs_t;

  logic clk = 1'b0;
  logic reset_button = 1'b0;
  longint edges = 0;
  longint now_edge = 0;
  int n_tests = 0;
  int n_fail = 0;
  int bright_a = 0;

  always #5 clk = ~clk;

  logic a_pe, a_hs, a_vs, a_br, a_ft; logic [9:0] a_h, a_v; logic [7:0] a_fc;
  logic b_pe, b_hs, b_vs, b_br, b_ft; logic [9:0] b_h, b_v; logic [7:0] b_fc;
  logic c_pe, c_hs, c_vs, c_br, c_ft; logic [9:0] c_h, c_v; logic [7:0] c_fc;

  vga_timing_gen #(
    .CLK_DIV(4), .H_SYNC(4), .H_VIS_START(6), .H_VIS_END(14), .H_TOTAL(16),
    .V_SYNC(2), .V_VIS_START(3), .V_VIS_END(9), .V_TOTAL(10)
  ) dut_a (
    .clk(clk), .reset_button(reset_button), .pix_en(a_pe), .hCount(a_h), .vCount(a_v),
    .hSync(a_hs), .vSync(a_vs), .bright(a_br), .frame_tick(a_ft), .frame_count(a_fc)
  );

  vga_timing_gen dut_b (
    .clk(clk), .reset_button(reset_button), .pix_en(b_pe), .hCount(b_h), .vCount(b_v),
    .hSync(b_hs), .vSync(b_vs), .bright(b_br), .frame_tick(b_ft), .frame_count(b_fc)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_SYNC(1), .H_VIS_START(2), .H_VIS_END(6), .H_TOTAL(8),
    .V_SYNC(1), .V_VIS_START(2), .V_VIS_END(5), .V_TOTAL(6)
  ) dut_c (
    .clk(clk), .reset_button(reset_button), .pix_en(c_pe), .hCount(c_h), .vCount(c_v),
    .hSync(c_hs), .vSync(c_vs), .bright(c_br), .frame_tick(c_ft), .frame_count(c_fc)
  );

  // Raster position follows from the number of completed pixel periods since release.
  function automatic obs_t model(input longint t, input int d, input int hs, input int hvs,
                                 input int hve, input int ht, input int vs, input int vvs,
                                 input int vve, input int vt);
    obs_t o;
    longint p, hp, vp, flen;
    p    = t / d;
    flen = longint'(ht) * vt;
    hp   = p % ht;
    vp   = (p / ht) % vt;
    o.pe = (t > 0) && ((t % d) == 0);
    o.h  = 10'(hp);
    o.v  = 10'(vp);
    o.hs = (hp >= hs);
    o.vs = (vp >= vs);
    o.br = (hp >= hvs) && (hp < hve) && (vp >= vvs) && (vp < vve);
    o.ft = o.pe && ((p % flen) == 0);
    o.fc = 8'((p / flen) % 256);
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d: got pe=%0b h=%0d v=%0d hs=%0b vs=%0b br=%0b ft=%0b fc=%0d, expected pe=%0b h=%0d v=%0d hs=%0b vs=%0b br=%0b ft=%0b fc=%0d",
               name, edges, act.pe, act.h, act.v, act.hs, act.vs, act.br, act.ft, act.fc,
               exp.pe, exp.h, exp.v, exp.hs, exp.vs, exp.br, exp.ft, exp.fc);
    end
  endtask

  task automatic check_val(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Clock edges since reset release, as seen by the model.
  always @(posedge clk or posedge reset_button) begin
    if (reset_button) edges <= 0;
    else edges <= edges + 1;
  end

  // Every-cycle comparison of all three builds against the model.
  always @(negedge clk) begin
    obs_t ea, eb, ec;
    if (reset_button) begin
      ea = '0; eb = '0; ec = '0;
    end else begin
      ea = model(edges, 4, 4, 6, 14, 16, 2, 3, 9, 10);
      eb = model(edges, 4, 96, 144, 784, 800, 2, 35, 515, 525);
      ec = model(edges, 1, 1, 2, 6, 8, 1, 2, 5, 6);
    end
    check_obs("cyc_a", {a_pe, a_h, a_v, a_hs, a_vs, a_br, a_ft, a_fc}, ea);
    check_obs("cyc_b", {b_pe, b_h, b_v, b_hs, b_vs, b_br, b_ft, b_fc}, eb);
    check_obs("cyc_c", {c_pe, c_h, c_v, c_hs, c_vs, c_br, c_ft, c_fc}, ec);
    if (!reset_button && a_pe && a_br && ((edges / 4) / 160) == 0) bright_a++;
  end

  task automatic goto(input longint n);
    repeat (int'(n - now_edge)) @(posedge clk);
    now_edge = n;
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 reset_button = 1'b0;
    now_edge = 0;
  endtask

  initial begin
    bit found;
    #1 reset_button = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_h", a_h, 0);
    check_val("reset_fc", a_fc, 0);
    release_reset();

    goto(19);  check_val("a_pe_e19", a_pe, 0);
    goto(20);  check_val("a_pe_e20", a_pe, 1);
               check_val("a_h_e20", a_h, 5);
               check_val("c_h_e20", c_h, 4);
    goto(383); check_val("b_h_e383", b_h, 95);
               check_val("b_hs_e383", b_hs, 0);
    goto(384); check_val("b_hs_e384", b_hs, 1);
    goto(640); check_val("a_ft_e640", a_ft, 1);
               check_val("a_fc_e640", a_fc, 1);
               check_val("a_bright_frame0", bright_a, 48);
    goto(641); check_val("a_ft_e641", a_ft, 0);
    goto(1280); check_val("a_fc_e1280", a_fc, 2);
    goto(3199); check_val("b_h_e3199", b_h, 799);
                check_val("b_v_e3199", b_v, 0);
    goto(3200); check_val("b_h_e3200", b_h, 0);
                check_val("b_v_e3200", b_v, 1);
    goto(12287); check_val("c_fc_e12287", c_fc, 255);
    goto(12288); check_val("c_fc_wrap", c_fc, 0);
                 check_val("c_ft_wrap", c_ft, 1);

    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(posedge clk); #1;
      if (a_v == 10'd5 && a_h == 10'd8 && !a_pe) found = 1'b1;
    end
    check_val("midframe_found", found, 1);
    #1 reset_button = 1'b1;
    #1;
    check_val("mid_rst_h", a_h, 0);
    check_val("mid_rst_v", a_v, 0);
    check_val("mid_rst_ft", a_ft, 0);
    check_val("mid_rst_fc", a_fc, 0);
    repeat (2) @(posedge clk);
    release_reset();
    goto(19); check_val("post_pe_e19", a_pe, 0);
    goto(20); check_val("post_pe_e20", a_pe, 1);
              check_val("post_h_e20", a_h, 5);
    goto(40); check_val("post_h_e40", a_h, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
